iq_mag_sq: RTL and testbench

//  Streaming I/Q power stage feeding the combinational square-root block: computes I^2+Q^2 per

---
 rtl/iq_mag_sq_if.sv | 23 ++
 rtl/iq_mag_sq.sv | 89 ++++++++
 tb/tb_iq_mag_sq.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/iq_mag_sq_if.sv
// Streaming I/Q power interface: signed I/Q samples in, unsigned power out,
// valid/ready on both sides. The slave side is the power block itself.
interface iq_mag_sq_if #(
  parameter int IN_W = 16
);
  logic signed [IN_W-1:0] in_i;
  logic signed [IN_W-1:0] in_q;
  logic                   in_valid;
  logic                   in_ready;
  logic [2*IN_W-1:0]      out_data;
  logic                   out_valid;
  logic                   out_ready;

  modport slave (
    input  in_i, in_q, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_i, in_q, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/iq_mag_sq.sv
// Two-stage I^2+Q^2 power pipeline with optional 2^AVG_LOG2 block averaging.
// A single global enable stalls every stage while a result waits for the consumer.
module iq_mag_sq #(
  parameter int IN_W     = 16,
  parameter int AVG_LOG2 = 0
) (
  input  logic         clk,
  input  logic         rst,
  iq_mag_sq_if.slave   bus
);
  localparam int OUT_W = 2 * IN_W;
  localparam int ACC_W = OUT_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((32'd1 << AVG_LOG2) - 32'd1);

  logic                    w_en;
  logic                    w_in_xfer;
  logic                    w_last;
  logic signed [OUT_W-1:0] w_i_ext;
  logic signed [OUT_W-1:0] w_q_ext;
  logic signed [OUT_W-1:0] w_prod_i;
  logic signed [OUT_W-1:0] w_prod_q;
  logic [OUT_W-1:0]        w_sum;
  logic [ACC_W-1:0]        w_acc_base;
  logic [ACC_W-1:0]        w_acc_next;

  logic                    r_s1_valid;
  logic [OUT_W-1:0]        r_sq_i;
  logic [OUT_W-1:0]        r_sq_q;
  logic [ACC_W-1:0]        r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic [OUT_W-1:0]        r_out_data;
  logic                    r_out_valid;

  assign w_en         = !r_out_valid || bus.out_ready;
  assign bus.in_ready = !rst && w_en;
  assign w_in_xfer    = bus.in_valid && bus.in_ready;

  // Squares are taken at full output width; the top bit is always zero, so the sum cannot wrap.
  assign w_i_ext  = OUT_W'(bus.in_i);
  assign w_q_ext  = OUT_W'(bus.in_q);
  assign w_prod_i = w_i_ext * w_i_ext;
  assign w_prod_q = w_q_ext * w_q_ext;
  assign w_sum    = r_sq_i + r_sq_q;
  assign w_last   = (r_cnt == CNT_LAST);

  // Accumulator restarts from zero at the first sample of each window.
  always_comb begin
    w_acc_base = {ACC_W{1'b0}};
    if (r_cnt == {CNT_W{1'b0}}) begin
      w_acc_base = {ACC_W{1'b0}};
    end else begin
      w_acc_base = r_acc;
    end
    w_acc_next = w_acc_base + ACC_W'(w_sum);
  end

  // Pipeline registers: squaring stage, then accumulate/average stage and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_sq_i      <= {OUT_W{1'b0}};
      r_sq_q      <= {OUT_W{1'b0}};
      r_acc       <= {ACC_W{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_out_data  <= {OUT_W{1'b0}};
      r_out_valid <= 1'b0;
    end else if (w_en) begin
      r_s1_valid <= w_in_xfer;
      if (w_in_xfer) begin
        r_sq_i <= w_prod_i;
        r_sq_q <= w_prod_q;
      end
      if (r_s1_valid) begin
        if (w_last) begin
          r_out_data <= w_acc_next[ACC_W-1:AVG_LOG2];
          r_cnt      <= {CNT_W{1'b0}};
        end else begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CNT_W'(1'b1);
        end
      end
      r_out_valid <= r_s1_valid && w_last;
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_iq_mag_sq.sv
// Directed and randomised checks of iq_mag_sq with AVG_LOG2 = 0, 2 and 3 instances.
module tb_iq_mag_sq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  iq_mag_sq_if #(.IN_W(16)) if0 ();
  iq_mag_sq_if #(.IN_W(16)) if2 ();
  iq_mag_sq_if #(.IN_W(16)) if3 ();

  iq_mag_sq #(.IN_W(16), .AVG_LOG2(0)) u_avg0 (.clk(clk), .rst(rst), .bus(if0));
  iq_mag_sq #(.IN_W(16), .AVG_LOG2(2)) u_avg2 (.clk(clk), .rst(rst), .bus(if2));
  iq_mag_sq #(.IN_W(16), .AVG_LOG2(3)) u_avg3 (.clk(clk), .rst(rst), .bus(if3));

  typedef struct {
    logic signed [15:0] i;
    logic signed [15:0] q;
    logic [31:0]        exp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  function automatic longint sq(input logic signed [15:0] v);
    return longint'(v) * longint'(v);
  endfunction

  function automatic logic [15:0] isqrt(input logic [31:0] n);
    logic [63:0] r;
    logic [63:0] t;
    r = 64'd0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= 64'(n)) r = t;
    end
    return r[15:0];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int k_in;
    int n_out;
    int cyc;
    bit stall;
    bit prev_stall;
    logic [31:0] held;
    logic [31:0] q0 [$];
    logic [31:0] q3 [$];
    longint acc3;
    int cnt3;

    vecs[0] = '{16'sd3,      16'sd4,      32'd25};
    vecs[1] = '{-16'sd32768, -16'sd32768, 32'h8000_0000};
    vecs[2] = '{16'sd32767,  -16'sd32768, 32'h7FFF_0001};
    vecs[3] = '{16'sd0,      16'sd0,      32'd0};
    vecs[4] = '{-16'sd1,     16'sd1,      32'd2};
    vecs[5] = '{16'sd100,    -16'sd200,   32'd50000};

    if0.in_valid = 1'b0; if0.in_i = 16'sd0; if0.in_q = 16'sd0; if0.out_ready = 1'b1;
    if2.in_valid = 1'b0; if2.in_i = 16'sd0; if2.in_q = 16'sd0; if2.out_ready = 1'b1;
    if3.in_valid = 1'b0; if3.in_i = 16'sd0; if3.in_q = 16'sd0; if3.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready0", 64'(if0.in_ready), 64'd0);
    chk("rst_out_valid0", 64'(if0.out_valid), 64'd0);
    chk("rst_out_data0", 64'(if0.out_data), 64'd0);
    chk("rst_out_valid2", 64'(if2.out_valid), 64'd0);
    chk("rst_in_ready3", 64'(if3.in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready0", 64'(if0.in_ready), 64'd1);

    // Single samples, AVG_LOG2=0: latency and value
    for (int v = 0; v < 6; v++) begin
      @(posedge clk); #1;
      if0.in_valid = 1'b1; if0.in_i = vecs[v].i; if0.in_q = vecs[v].q;
      @(negedge clk);
      chk("vec_in_ready", 64'(if0.in_ready), 64'd1);
      @(posedge clk); #1;
      if0.in_valid = 1'b0; if0.in_i = 16'sh5A5A; if0.in_q = -16'sh1234;
      @(negedge clk);
      chk("vec_not_early", 64'(if0.out_valid), 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk("vec_valid", 64'(if0.out_valid), 64'd1);
      chk("vec_data", 64'(if0.out_data), 64'(vecs[v].exp));
      if (v == 0) chk("vec_sqrt", 64'(isqrt(if0.out_data)), 64'd5);
    end

    // Back-to-back throughput, AVG_LOG2=0
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if0.in_valid = (c < 3);
      if0.in_i = 16'(c + 1); if0.in_q = 16'(c + 1);
      @(negedge clk);
      if (c >= 2) begin
        chk("b2b_valid", 64'(if0.out_valid), 64'd1);
        chk("b2b_data", 64'(if0.out_data), 64'(2 * (c - 1) * (c - 1)));
      end
    end

    // Averaging window of 4, AVG_LOG2=2
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1;
      if2.in_valid = (c < 8);
      case (c)
        0:       begin if2.in_i = 16'sd1;   if2.in_q = 16'sd0; end
        1:       begin if2.in_i = 16'sd0;   if2.in_q = 16'sd2; end
        2:       begin if2.in_i = 16'sd2;   if2.in_q = 16'sd2; end
        3:       begin if2.in_i = 16'sd3;   if2.in_q = 16'sd0; end
        default: begin if2.in_i = 16'sd100; if2.in_q = 16'sd0; end
      endcase
      @(negedge clk);
      if (c >= 1) chk("avg2_valid", 64'(if2.out_valid), 64'((c == 5) || (c == 9)));
      if (c == 5) chk("avg2_data_a", 64'(if2.out_data), 64'd5);
      if (c == 9) chk("avg2_data_b", 64'(if2.out_data), 64'd10000);
    end

    // Backpressure on ramp stream, AVG_LOG2=0
    k_in = 0; n_out = 0; cyc = 0; prev_stall = 1'b0; held = 32'd0;
    while (n_out < 10 && cyc < 100) begin
      @(posedge clk); #1;
      if0.out_ready = !(cyc >= 4 && cyc < 9);
      if0.in_valid = (k_in < 10);
      if0.in_i = 16'(k_in + 1); if0.in_q = 16'(k_in + 1);
      @(negedge clk);
      stall = if0.out_valid && !if0.out_ready;
      if (stall) begin
        chk("bp_in_ready_low", 64'(if0.in_ready), 64'd0);
        if (prev_stall) chk("bp_data_held", 64'(if0.out_data), 64'(held));
      end
      held = if0.out_data;
      prev_stall = stall;
      if (if0.in_valid && if0.in_ready) k_in++;
      if (if0.out_valid && if0.out_ready) begin
        chk("bp_data", 64'(if0.out_data), 64'(2 * (n_out + 1) * (n_out + 1)));
        n_out++;
      end
      cyc++;
    end
    chk("bp_outputs_count", 64'(n_out), 64'd10);
    @(posedge clk); #1;
    if0.in_valid = 1'b0; if0.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_no_dup", 64'(if0.out_valid), 64'd0);
    end

    // Reset in mid-window, AVG_LOG2=2
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      rst = (c == 2);
      if2.in_valid = (c < 2) || (c >= 3 && c < 7);
      if (c < 2) begin if2.in_i = 16'sd5; if2.in_q = 16'sd5; end
      else       begin if2.in_i = 16'sd1; if2.in_q = 16'sd1; end
      @(negedge clk);
      if (c == 2) chk("rstmid_in_ready", 64'(if2.in_ready), 64'd0);
      if (c >= 3) chk("rstmid_valid", 64'(if2.out_valid), 64'(c == 8));
      if (c == 8) chk("rstmid_data", 64'(if2.out_data), 64'd2);
    end

    // Random stream with scoreboard, AVG_LOG2 0 and 3
    acc3 = 0; cnt3 = 0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      if (c < 450) begin
        if0.in_valid = ($urandom_range(0, 3) != 0);
        if0.out_ready = ($urandom_range(0, 3) != 0);
        if3.in_valid = ($urandom_range(0, 3) != 0);
        if3.out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        if0.in_valid = 1'b0; if0.out_ready = 1'b1;
        if3.in_valid = 1'b0; if3.out_ready = 1'b1;
      end
      if0.in_i = 16'($urandom); if0.in_q = 16'($urandom);
      if3.in_i = 16'($urandom); if3.in_q = 16'($urandom);
      @(negedge clk);
      if (if0.out_valid && if0.out_ready) begin
        if (q0.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL rand0_extra: got output %0d expected none", if0.out_data);
        end else begin
          chk("rand0_data", 64'(if0.out_data), 64'(q0.pop_front()));
        end
      end
      if (if0.in_valid && if0.in_ready) q0.push_back(32'(sq(if0.in_i) + sq(if0.in_q)));
      if (if3.out_valid && if3.out_ready) begin
        if (q3.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL rand3_extra: got output %0d expected none", if3.out_data);
        end else begin
          chk("rand3_data", 64'(if3.out_data), 64'(q3.pop_front()));
        end
      end
      if (if3.in_valid && if3.in_ready) begin
        acc3 += sq(if3.in_i) + sq(if3.in_q);
        cnt3++;
        if (cnt3 == 8) begin
          q3.push_back(32'(acc3 >> 3));
          acc3 = 0; cnt3 = 0;
        end
      end
    end
    chk("rand0_drained", 64'(q0.size()), 64'd0);
    chk("rand3_drained", 64'(q3.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
